// File: rtl/matrix_column_scanner_pkg.sv
// Shared panel definitions for the column scanner: FSM state encoding and
// width helpers for column index and phase counters.
package matrix_column_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/matrix_column_scanner_column_mux.sv
// Selects one N_ROWS-wide column slice out of a packed frame buffer;
// parametrised successor of the fixed 5-input column multiplexer.
module column_mux
    import matrix_column_scanner_pkg::*;
#(
    parameter int N_ROWS = 7,
    parameter int N_COLS = 5,
    parameter int IDX_W  = idx_width(N_COLS)
) (
    input  logic [N_ROWS*N_COLS-1:0] data,
    input  logic [IDX_W-1:0]         sel,
    output logic [N_ROWS-1:0]        slice
);

    always_comb begin
        slice = '0;
        for (int unsigned c = 0; c < N_COLS; c++) begin
            if (sel == IDX_W'(c)) begin
                slice = data[c*N_ROWS +: N_ROWS];
            end
        end
    end

endmodule

// File: rtl/matrix_column_scanner.sv
// LED matrix column scanner: blank/drive timing per column, double-buffered
// frame input swapped only at frame boundaries, registered drive outputs.
module matrix_column_scanner
    import matrix_column_scanner_pkg::*;
#(
    parameter int N_ROWS       = 7,
    parameter int N_COLS       = 5,
    parameter int BLANK_CYCLES = 2,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     invert,
    input  logic [N_ROWS*N_COLS-1:0] frame_data,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    output logic [N_COLS-1:0]        col_sel,
    output logic [N_ROWS-1:0]        row_out,
    output logic                     frame_start
);

    localparam int IDX_W = idx_width(N_COLS);
    localparam int CNT_W = idx_width(max_int(BLANK_CYCLES, DWELL_CYCLES));
    localparam int FW    = N_ROWS * N_COLS;

    scan_state_t        state, state_next;
    logic [IDX_W-1:0]   col_idx, col_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [FW-1:0]      active_buf, shadow_buf;
    logic               pending;
    logic               frame_entry, swap, accept;
    logic [N_ROWS-1:0]  slice;
    logic [N_COLS-1:0]  onehot;

    column_mux #(
        .N_ROWS (N_ROWS),
        .N_COLS (N_COLS),
        .IDX_W  (IDX_W)
    ) u_column_mux (
        .data  (active_buf),
        .sel   (col_idx),
        .slice (slice)
    );

    always_comb begin
        state_next = state;
        col_next   = col_idx;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_next = BLANK;
                    col_next   = '0;
                    cnt_next   = '0;
                end
            end
            BLANK: begin
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DRIVE: begin
                if (cnt == CNT_W'(DWELL_CYCLES - 1)) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    col_next   = (col_idx == IDX_W'(N_COLS - 1)) ? '0 : col_idx + IDX_W'(1);
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                col_next   = '0;
                cnt_next   = '0;
            end
        endcase
        if (!enable) begin
            state_next = IDLE;
            col_next   = '0;
            cnt_next   = '0;
        end
    end

    // Entering BLANK at column 0 from anywhere but BLANK is the frame boundary.
    assign frame_entry = (state_next == BLANK) && (col_next == '0) && (state != BLANK);
    assign swap        = frame_entry && pending;
    assign accept      = frame_valid && !pending;
    assign frame_ready = !pending;
    // DRIVE never follows a column change, so the current col_idx is the one driven next.
    assign onehot      = N_COLS'(1) << col_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            col_idx     <= '0;
            cnt         <= '0;
            active_buf  <= '0;
            shadow_buf  <= '0;
            pending     <= 1'b0;
            col_sel     <= '0;
            row_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            col_idx     <= col_next;
            cnt         <= cnt_next;
            frame_start <= frame_entry;
            if (swap) begin
                active_buf <= shadow_buf;
                pending    <= 1'b0;
            end else if (accept) begin
                shadow_buf <= frame_data;
                pending    <= 1'b1;
            end
            if (state_next == DRIVE) begin
                col_sel <= onehot;
                row_out <= slice ^ {N_ROWS{invert}};
            end else begin
                col_sel <= '0;
                row_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Scoreboard bench for matrix_column_scanner: a frame-position reference model
// queues the expected outputs per cycle and a monitor compares them.
module tb_matrix_column_scanner;

    localparam int N_ROWS = 7;
    localparam int N_COLS = 5;
    localparam int BLANK_CYCLES = 2;
    localparam int DWELL_CYCLES = 4;
    localparam int FW = N_ROWS * N_COLS;
    localparam int CP = BLANK_CYCLES + DWELL_CYCLES;
    localparam int FP = N_COLS * CP;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              invert = 1'b0;
    logic [FW-1:0]     frame_data = '0;
    logic              frame_valid = 1'b0;
    logic              frame_ready;
    logic [N_COLS-1:0] col_sel;
    logic [N_ROWS-1:0] row_out;
    logic              frame_start;

    int checks = 0;
    int failures = 0;

    matrix_column_scanner #(
        .N_ROWS       (N_ROWS),
        .N_COLS       (N_COLS),
        .BLANK_CYCLES (BLANK_CYCLES),
        .DWELL_CYCLES (DWELL_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .invert      (invert),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .col_sel     (col_sel),
        .row_out     (row_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_COLS-1:0] cs;
        logic [N_ROWS-1:0] ro;
        logic              fs;
        logic              fr;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, act, req);
        end
    endtask

    // Reference model: frame position p counts cycles since the frame boundary.
    logic [FW-1:0] m_active, m_shadow, m_tmp;
    bit            m_pending, m_run, m_acc;
    int            m_p, m_col, m_q;
    exp_t          m_e;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = '0; m_shadow = '0; m_pending = 0; m_run = 0; m_p = 0;
            exp_q.delete();
        end else begin
            m_acc = frame_valid && !m_pending;
            m_e.cs = '0; m_e.ro = '0; m_e.fs = 1'b0;
            if (!enable) begin
                m_run = 0;
                m_p = 0;
            end else begin
                if (!m_run) begin m_run = 1; m_p = 0; end
                else m_p = (m_p + 1) % FP;
                if (m_p == 0 && m_pending) begin m_active = m_shadow; m_pending = 0; end
                m_col = m_p / CP;
                m_q = m_p % CP;
                if (m_q >= BLANK_CYCLES) begin
                    m_e.cs = N_COLS'(1) << m_col;
                    m_tmp = m_active >> (m_col * N_ROWS);
                    m_e.ro = m_tmp[N_ROWS-1:0] ^ (invert ? {N_ROWS{1'b1}} : '0);
                end
                m_e.fs = (m_p == 0);
            end
            if (m_acc) begin m_shadow = frame_data; m_pending = 1; end
            m_e.fr = !m_pending;
            exp_q.push_back(m_e);
        end
    end

    exp_t mon_e;
    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("col_sel", int'(col_sel), int'(mon_e.cs));
                check("row_out", int'(row_out), int'(mon_e.ro));
                check("frame_start", int'(frame_start), int'(mon_e.fs));
                check("frame_ready", int'(frame_ready), int'(mon_e.fr));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [N_COLS-1:0] target, input int limit);
        int n = 0;
        while (col_sel !== target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_col", int'(col_sel), int'(target));
    endtask

    task automatic offer(input logic [FW-1:0] data, input int limit);
        int n = 0;
        @(negedge clk);
        frame_data = data;
        frame_valid = 1'b1;
        while (!frame_ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("offer_ready_timeout", int'(frame_ready), 1);
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[FW-1:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog at %0t: simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] fa;
        cycles(3);
        check("reset_col_sel", int'(col_sel), 0);
        check("reset_row_out", int'(row_out), 0);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_frame_ready", int'(frame_ready), 1);
        rst_n = 1'b1;

        // Empty frame scan
        cycles(2);
        enable = 1'b1;
        cycles(2 * FP + 5);

        // Column 0 = 7'h55 loaded while idle, then plain and inverted display
        enable = 1'b0;
        fa = '0;
        fa[N_ROWS-1:0] = 7'h55;
        offer(fa, 10);
        cycles(2);
        enable = 1'b1;
        wait_col(5'b00001, 3 * FP);
        check("col0_row", int'(row_out), 'h55);
        invert = 1'b1;
        wait_col(5'b00010, 3 * FP);
        check("col1_row_inv", int'(row_out), 'h7F);
        wait_col(5'b00001, 3 * FP);
        check("col0_row_inv", int'(row_out), 'h2A);
        invert = 1'b0;

        // B mid-frame, then C stalled until B swaps in
        wait_col(5'b00100, 3 * FP);
        offer(rand_frame(), 10);
        check("ready_low_after_b", int'(frame_ready), 0);
        offer(rand_frame(), 3 * FP);
        cycles(2 * FP + 3);

        // Drop enable during column 3, then restart
        wait_col(5'b01000, 3 * FP);
        enable = 1'b0;
        cycles(4);
        enable = 1'b1;
        cycles(FP + 4);

        // Asynchronous reset during column 2 with a frame pending
        wait_col(5'b00100, 3 * FP);
        offer(rand_frame(), 3 * FP);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_col_sel", int'(col_sel), 0);
        check("async_row_out", int'(row_out), 0);
        check("async_frame_ready", int'(frame_ready), 1);
        check("async_frame_start", int'(frame_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(FP + 5);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            enable = ($urandom_range(59) != 0);
            if ($urandom_range(19) == 0) invert = ~invert;
            frame_valid = ($urandom_range(3) == 0);
            frame_data = rand_frame();
        end
        @(negedge clk);
        frame_valid = 1'b0;
        cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_column_scanner.md
MATRIX_COLUMN_SCANNER -- requirements
Module: matrix_column_scanner

Interface
REQ-001 Parameter N_ROWS, default 7: LEDs per column (row lines).
REQ-002 Parameter N_COLS, default 5: columns scanned per frame.
REQ-003 Parameter BLANK_CYCLES, default 2: cycles with all lines off between columns (anti-ghosting); SHALL be >= 1.
REQ-004 Parameter DWELL_CYCLES, default 4: cycles a column is driven; SHALL be >= 1.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  the single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 enable  input  1  scanning runs while high.
REQ-009 invert  input  1  when high, row_out drives the complement of the stored pixel bits.
REQ-010 frame_data  input  N_ROWS*N_COLS  new frame; column c occupies bits [c*N_ROWS +: N_ROWS].
REQ-011 frame_valid  input  1  frame_data offered.
REQ-012 frame_ready  output  1  frame is accepted when frame_valid and frame_ready are both high.
REQ-013 col_sel  output  N_COLS  one-hot active-high column enable.
REQ-014 row_out  output  N_ROWS  row drive for the selected column.
REQ-015 frame_start  output  1  one-cycle pulse marking the start of each frame.

Function
REQ-016 The FSM SHALL have three states: IDLE, BLANK and DRIVE, plus a column index col_idx in 0..N_COLS-1.
REQ-017 IDLE -> BLANK when enable=1, with col_idx=0.
REQ-018 BLANK SHALL last exactly BLANK_CYCLES cycles, then go to DRIVE.
REQ-019 DRIVE SHALL last exactly DWELL_CYCLES cycles, then go to BLANK with col_idx+1; after N_COLS-1 it wraps to 0.
REQ-020 Column period SHALL be BLANK_CYCLES+DWELL_CYCLES; frame period SHALL be N_COLS*(BLANK_CYCLES+DWELL_CYCLES).
REQ-021 col_sel and row_out SHALL be registered and non-zero only during DRIVE cycles.
REQ-022 During DRIVE: col_sel = one-hot(col_idx); row_out = active[col_idx*N_ROWS +: N_ROWS], XOR-ed with invert.
REQ-023 During BLANK and IDLE: col_sel=0 and row_out=0, regardless of invert.
REQ-024 Double buffering: an accepted frame SHALL be written to a shadow register and set pending; frame_ready = ~pending.
REQ-025 The active buffer SHALL only change on entry into BLANK with col_idx=0 (from IDLE or from the wrap). On that entry, if pending is set, the shadow is copied to the active buffer and pending is cleared.
REQ-026 A displayed frame SHALL never mix columns from two frames.
REQ-027 frame_start SHALL pulse high for exactly the first cycle of BLANK with col_idx=0.
REQ-028 enable=0 in any state SHALL give IDLE on the next edge, with col_idx=0 and outputs zero. The shadow buffer, pending flag and active buffer are kept.
REQ-029 An accept and a swap cannot coincide, because ready is low while pending. An accept in the swap cycle's successor SHALL be held for the next frame.

Reset
REQ-030 Reset SHALL force the following: state=IDLE, col_idx=0, both buffers all-zero, pending=0 (frame_ready=1), col_sel=0, row_out=0, frame_start=0.
REQ-031 Reset asserted mid-frame SHALL take effect immediately and asynchronously. After release, scanning restarts at column 0 with a blank frame.

Structure
REQ-032 The FSM state encoding and the column/row width helper constants SHALL live in the shared panel package.
REQ-033 One sub-module, column_mux, SHALL select the N_ROWS-wide slice by col_idx. It is the parametrised successor of the fixed 5-input column multiplexer.
REQ-034 The target size is 120-400 RTL lines, with no latches and no combinational path from frame_valid to col_sel or row_out.

Verification (N_ROWS=7, N_COLS=5, BLANK_CYCLES=2, DWELL_CYCLES=4)
REQ-035 Reset, then enable=1 with no frame loaded -> frame_start at cycle 1; col_sel goes 0,0,00001x4,0,0,00010x4,… and row_out stays 0; 30-cycle frame period.
REQ-036 Load column 0=7'h55, others 0, before enable -> row_out=7'h55 exactly while col_sel=5'b00001; with invert=1 it shows 7'h2A there and 7'h7F in the other columns.
REQ-037 Offer frame B mid-frame A -> accepted, frame_ready=0 until the next frame_start. Frame A completes unchanged, and B appears from column 0.
REQ-038 Offer B and then C within one frame -> C is stalled (frame_ready=0) until B swaps in. C is then accepted, and B is displayed for one full frame.
REQ-039 Drop enable during DRIVE of column 3 -> the next cycle gives col_sel=0 and row_out=0 in IDLE. Re-enabling restarts at column 0 with frame_start.
REQ-040 Assert rst_n=0 during DRIVE of column 2 -> outputs are zero without a clock edge, and frame_ready=1. After release, a blank frame is scanned.
